mips_mc_ctrl: RTL and testbench

Parametrised multicycle MIPS control unit, successor to the fixed-latency controller FSM. It adds a request/acknowledge memory handshake with wait states and a timeout, plus the immediate-logic, bne and j instructions. It also adds an illegal-opcode/timeout error state and a retired-instruction counter. It sits beside the datapath, driving its control strobes from the decoded opcode.

---
 rtl/mips_mc_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: opcode-driven FSM with req/ack memory handshake,
// wait-state timeout, sticky error reporting and a retired-instruction counter.
module mips_mc_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              IorD,
  output logic              ALUSrcA,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              RegDst,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              Branch,
  output logic              BranchNE,
  output logic              ZeroExt,
  output logic [1:0]        ALUSrcB,
  output logic [2:0]        ALUOp,
  output logic [1:0]        PCSrc,
  output logic [3:0]        state_o,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [PERF_W-1:0] instr_cnt
);

  localparam int unsigned     WaitW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              TmoEn   = (TIMEOUT != 0);

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StImmEx   = 4'd9,
    StImmWb   = 4'd10,
    StJump    = 4'd11,
    StError   = 4'd12
  } state_e;

  state_e              r_state;
  state_e              w_next;
  logic [WaitW-1:0]    r_wait;
  logic                r_err;
  logic [1:0]          r_err_code;
  logic [PERF_W-1:0]   r_instr_cnt;
  logic                r_zext;
  logic                w_mem_state;
  logic                w_tmo_hit;
  logic                w_tmo;
  logic                w_ill;
  logic                w_imm_zext;

  assign w_mem_state = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
  // Ack in the last allowed cycle still completes the access.
  assign w_tmo_hit   = TmoEn && (r_wait == WaitMax) && !mem_ack;
  assign w_imm_zext  = (op == OpAndi) || (op == OpOri);

  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    w_ill  = 1'b0;
    case (r_state)
      StFetch: begin
        if (mem_ack) w_next = StDecode;
        else if (w_tmo_hit) begin w_next = StError; w_tmo = 1'b1; end
      end
      StDecode: begin
        case (op)
          OpLw, OpSw:            w_next = StMemAdr;
          OpR:                   w_next = StExecute;
          OpBeq, OpBne:          w_next = StBranch;
          OpAddi, OpAndi, OpOri: w_next = StImmEx;
          OpJ:                   w_next = StJump;
          default: begin w_next = StError; w_ill = 1'b1; end
        endcase
      end
      StMemAdr:  w_next = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ack) w_next = StMemWb;
        else if (w_tmo_hit) begin w_next = StError; w_tmo = 1'b1; end
      end
      StMemWr: begin
        if (mem_ack) w_next = StFetch;
        else if (w_tmo_hit) begin w_next = StError; w_tmo = 1'b1; end
      end
      StMemWb, StAluWb, StBranch, StImmWb, StJump: w_next = StFetch;
      StExecute: w_next = StAluWb;
      StImmEx:   w_next = StImmWb;
      StError:   w_next = StError;
      default:   w_next = StError;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StFetch;
      r_wait      <= '0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
      r_instr_cnt <= '0;
      r_zext      <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) &&
          ((w_next == StFetch) || (w_next == StMemRd) || (w_next == StMemWr))) begin
        r_wait <= '0;
      end else if (w_mem_state && !mem_ack) begin
        r_wait <= r_wait + 1'b1;
      end
      // Every completed instruction re-enters FETCH exactly once.
      if ((w_next == StFetch) && (r_state != StFetch)) r_instr_cnt <= r_instr_cnt + 1'b1;
      if (w_ill) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b01;
      end
      if (w_tmo) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b10;
      end
      if (r_state == StImmEx) r_zext <= w_imm_zext;
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    BranchNE = 1'b0;
    ZeroExt  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 3'b000;
    PCSrc    = 2'b00;
    // Strobes are forced low for the whole time reset is held.
    if (rst) begin
      case (r_state)
        StFetch: begin
          mem_req = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ack;
          PCWrite = mem_ack;
        end
        StDecode:  ALUSrcB = 2'b11;
        StMemAdr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        StMemRd: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        StMemWb: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        StMemWr: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        StExecute: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b010;
        end
        StAluWb: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        StBranch: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 3'b001;
          PCSrc    = 2'b01;
          Branch   = (op == OpBeq);
          BranchNE = (op == OpBne);
        end
        StImmEx: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ZeroExt = w_imm_zext;
          if (op == OpAndi)     ALUOp = 3'b011;
          else if (op == OpOri) ALUOp = 3'b100;
        end
        StImmWb: begin
          RegWrite = 1'b1;
          ZeroExt  = r_zext;
        end
        StJump: begin
          PCSrc   = 2'b10;
          PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o   = r_state;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl with a short memory timeout (TIMEOUT=4).
module tb_mips_mc_ctrl;

  localparam logic [3:0] SFetch = 4'd0, SDecode = 4'd1, SMemAdr = 4'd2, SMemRd = 4'd3;
  localparam logic [3:0] SMemWb = 4'd4, SMemWr = 4'd5, SExec = 4'd6, SAluWb = 4'd7;
  localparam logic [3:0] SBranch = 4'd8, SImmEx = 4'd9, SImmWb = 4'd10, SJump = 4'd11;
  localparam logic [3:0] SError = 4'd12;

  localparam logic [5:0] OpR = 6'b000000, OpJ = 6'b000010, OpBeq = 6'b000100;
  localparam logic [5:0] OpBne = 6'b000101, OpAddi = 6'b001000, OpAndi = 6'b001100;
  localparam logic [5:0] OpOri = 6'b001101, OpLw = 6'b100011, OpSw = 6'b101011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  op = 6'd0;
  logic        mem_ack = 1'b0;
  logic        mem_req, IorD, ALUSrcA, IRWrite, PCWrite, RegDst, MemtoReg, RegWrite;
  logic        MemWrite, Branch, BranchNE, ZeroExt, err;
  logic [1:0]  ALUSrcB, PCSrc, err_code;
  logic [2:0]  ALUOp;
  logic [3:0]  state_o;
  logic [31:0] instr_cnt;
  int          total = 0;
  int          bad = 0;

  mips_mc_ctrl #(.TIMEOUT(4), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ack(mem_ack), .mem_req(mem_req), .IorD(IorD),
    .ALUSrcA(ALUSrcA), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite), .Branch(Branch),
    .BranchNE(BranchNE), .ZeroExt(ZeroExt), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .state_o(state_o), .err(err), .err_code(err_code),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; mem_ack = 1'b0; op = 6'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    op = OpLw; mem_ack = 1'b1;
    #1;
    total++; if (state_o !== SFetch) begin bad++; $display("FAIL rst_state got=%0d want=%0d", state_o, SFetch); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0b want=0", mem_req); end
    @(posedge clk); #1;
    total++; if ({IRWrite, PCWrite, ALUSrcB} !== 4'b0) begin bad++; $display("FAIL rst_strobes got=%0h want=0", {IRWrite, PCWrite, ALUSrcB}); end
    total++; if ({err, err_code} !== 3'b0) begin bad++; $display("FAIL rst_err got=%0h want=0", {err, err_code}); end
    total++; if (instr_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", instr_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_lw;
    op = OpLw; mem_ack = 1'b1; #1;
    total++; if ({state_o, mem_req, IRWrite, PCWrite, ALUSrcB} !== {SFetch, 3'b111, 2'b01}) begin bad++; $display("FAIL lw_fetch got=%0h want=%0h", {state_o, mem_req, IRWrite, PCWrite, ALUSrcB}, {SFetch, 3'b111, 2'b01}); end
    tick;
    total++; if ({state_o, ALUSrcB, IRWrite} !== {SDecode, 2'b11, 1'b0}) begin bad++; $display("FAIL lw_decode got=%0h want=%0h", {state_o, ALUSrcB, IRWrite}, {SDecode, 2'b11, 1'b0}); end
    tick;
    total++; if ({state_o, ALUSrcA, ALUSrcB} !== {SMemAdr, 1'b1, 2'b10}) begin bad++; $display("FAIL lw_memadr got=%0h want=%0h", {state_o, ALUSrcA, ALUSrcB}, {SMemAdr, 1'b1, 2'b10}); end
    tick;
    total++; if ({state_o, mem_req, IorD} !== {SMemRd, 2'b11}) begin bad++; $display("FAIL lw_memrd got=%0h want=%0h", {state_o, mem_req, IorD}, {SMemRd, 2'b11}); end
    tick;
    total++; if ({state_o, RegWrite, MemtoReg, RegDst} !== {SMemWb, 3'b110}) begin bad++; $display("FAIL lw_memwb got=%0h want=%0h", {state_o, RegWrite, MemtoReg, RegDst}, {SMemWb, 3'b110}); end
    tick;
    total++; if ({state_o, instr_cnt} !== {SFetch, 32'd1}) begin bad++; $display("FAIL lw_retire got=%0h want=%0h", {state_o, instr_cnt}, {SFetch, 32'd1}); end
  endtask

  task automatic test_sw_wait;
    op = OpSw; mem_ack = 1'b1; #1;
    tick; tick; tick;
    mem_ack = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      total++; if ({state_o, MemWrite, mem_req, RegWrite} !== {SMemWr, 3'b110}) begin bad++; $display("FAIL sw_wait%0d got=%0h want=%0h", i, {state_o, MemWrite, mem_req, RegWrite}, {SMemWr, 3'b110}); end
      tick;
    end
    mem_ack = 1'b1; #1;
    total++; if ({state_o, MemWrite, err} !== {SMemWr, 2'b10}) begin bad++; $display("FAIL sw_ack got=%0h want=%0h", {state_o, MemWrite, err}, {SMemWr, 2'b10}); end
    tick;
    total++; if ({state_o, MemWrite, instr_cnt} !== {SFetch, 1'b0, 32'd2}) begin bad++; $display("FAIL sw_done got=%0h want=%0h", {state_o, MemWrite, instr_cnt}, {SFetch, 1'b0, 32'd2}); end
  endtask

  task automatic test_imm(input logic [5:0] opc, input logic [2:0] aluop, input logic zx);
    op = opc; mem_ack = 1'b1; #1;
    tick;
    total++; if ({state_o, ZeroExt} !== {SDecode, 1'b0}) begin bad++; $display("FAIL imm_decode op=%0h got=%0h want=%0h", opc, {state_o, ZeroExt}, {SDecode, 1'b0}); end
    tick;
    total++; if ({state_o, ALUOp, ZeroExt, ALUSrcA, ALUSrcB, RegWrite} !== {SImmEx, aluop, zx, 1'b1, 2'b10, 1'b0}) begin bad++; $display("FAIL imm_ex op=%0h got=%0h want=%0h", opc, {state_o, ALUOp, ZeroExt, ALUSrcA, ALUSrcB, RegWrite}, {SImmEx, aluop, zx, 1'b1, 2'b10, 1'b0}); end
    tick;
    total++; if ({state_o, ZeroExt, RegWrite, RegDst, MemtoReg} !== {SImmWb, zx, 3'b100}) begin bad++; $display("FAIL imm_wb op=%0h got=%0h want=%0h", opc, {state_o, ZeroExt, RegWrite, RegDst, MemtoReg}, {SImmWb, zx, 3'b100}); end
    tick;
  endtask

  task automatic test_branch(input logic [5:0] opc, input logic is_bne);
    op = opc; mem_ack = 1'b1; #1;
    tick; tick;
    total++; if ({state_o, Branch, BranchNE, PCSrc, ALUOp, ALUSrcA, ALUSrcB} !== {SBranch, ~is_bne, is_bne, 2'b01, 3'b001, 1'b1, 2'b00}) begin bad++; $display("FAIL branch op=%0h got=%0h want=%0h", opc, {state_o, Branch, BranchNE, PCSrc, ALUOp, ALUSrcA, ALUSrcB}, {SBranch, ~is_bne, is_bne, 2'b01, 3'b001, 1'b1, 2'b00}); end
    tick;
    total++; if ({state_o, BranchNE, Branch} !== {SFetch, 2'b00}) begin bad++; $display("FAIL branch_done got=%0h want=%0h", {state_o, BranchNE, Branch}, {SFetch, 2'b00}); end
  endtask

  task automatic test_jump;
    op = OpJ; mem_ack = 1'b1; #1;
    tick; tick;
    total++; if ({state_o, PCSrc, PCWrite} !== {SJump, 2'b10, 1'b1}) begin bad++; $display("FAIL jump got=%0h want=%0h", {state_o, PCSrc, PCWrite}, {SJump, 2'b10, 1'b1}); end
    tick;
  endtask

  task automatic test_rtype;
    op = OpR; mem_ack = 1'b1; #1;
    tick; tick;
    total++; if ({state_o, ALUOp, ALUSrcA, ALUSrcB} !== {SExec, 3'b010, 1'b1, 2'b00}) begin bad++; $display("FAIL rtype_ex got=%0h want=%0h", {state_o, ALUOp, ALUSrcA, ALUSrcB}, {SExec, 3'b010, 1'b1, 2'b00}); end
    tick;
    total++; if ({state_o, RegDst, RegWrite, MemtoReg} !== {SAluWb, 3'b110}) begin bad++; $display("FAIL rtype_wb got=%0h want=%0h", {state_o, RegDst, RegWrite, MemtoReg}, {SAluWb, 3'b110}); end
    tick;
  endtask

  task automatic test_sequence;
    do_reset;
    test_imm(OpAddi, 3'b000, 1'b0);
    test_imm(OpAndi, 3'b011, 1'b1);
    test_imm(OpOri, 3'b100, 1'b1);
    test_branch(OpBne, 1'b1);
    test_jump;
    test_rtype;
    total++; if (instr_cnt !== 32'd6) begin bad++; $display("FAIL seq_cnt got=%0d want=6", instr_cnt); end
    test_branch(OpBeq, 1'b0);
    total++; if (instr_cnt !== 32'd7) begin bad++; $display("FAIL seq_cnt_beq got=%0d want=7", instr_cnt); end
  endtask

  task automatic test_illegal;
    do_reset;
    op = 6'b111111; mem_ack = 1'b1; #1;
    tick;
    total++; if ({state_o, err} !== {SDecode, 1'b0}) begin bad++; $display("FAIL ill_decode got=%0h want=%0h", {state_o, err}, {SDecode, 1'b0}); end
    tick;
    total++; if ({state_o, err, err_code} !== {SError, 1'b1, 2'b01}) begin bad++; $display("FAIL ill_err got=%0h want=%0h", {state_o, err, err_code}, {SError, 1'b1, 2'b01}); end
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i % 2 == 0); #1;
      total++; if ({state_o, mem_req, IRWrite, err_code} !== {SError, 2'b00, 2'b01}) begin bad++; $display("FAIL ill_hold%0d got=%0h want=%0h", i, {state_o, mem_req, IRWrite, err_code}, {SError, 2'b00, 2'b01}); end
      tick;
    end
  endtask

  task automatic test_timeout;
    do_reset;
    op = OpAddi; mem_ack = 1'b0; #1;
    tick; tick; tick;
    total++; if ({state_o, err, mem_req} !== {SFetch, 2'b01}) begin bad++; $display("FAIL tmo_wait got=%0h want=%0h", {state_o, err, mem_req}, {SFetch, 2'b01}); end
    tick;
    total++; if ({state_o, err, err_code} !== {SError, 1'b1, 2'b10}) begin bad++; $display("FAIL tmo_err got=%0h want=%0h", {state_o, err, err_code}, {SError, 1'b1, 2'b10}); end
    do_reset;
    op = OpAddi; mem_ack = 1'b0; #1;
    tick; tick; tick;
    mem_ack = 1'b1; #1;
    total++; if ({IRWrite, PCWrite} !== 2'b11) begin bad++; $display("FAIL tmo_late_ack got=%0b want=11", {IRWrite, PCWrite}); end
    tick;
    total++; if ({state_o, err, err_code} !== {SDecode, 3'b000}) begin bad++; $display("FAIL tmo_ack_wins got=%0h want=%0h", {state_o, err, err_code}, {SDecode, 3'b000}); end
  endtask

  task automatic test_reset_mid_access;
    do_reset;
    test_jump;
    total++; if (instr_cnt !== 32'd1) begin bad++; $display("FAIL mid_pre_cnt got=%0d want=1", instr_cnt); end
    op = OpLw; mem_ack = 1'b1; #1;
    tick; tick; tick;
    mem_ack = 1'b0; #1;
    total++; if ({state_o, mem_req, IorD} !== {SMemRd, 2'b11}) begin bad++; $display("FAIL mid_memrd got=%0h want=%0h", {state_o, mem_req, IorD}, {SMemRd, 2'b11}); end
    #2 rst = 1'b0;
    #1;
    total++; if ({state_o, mem_req, IorD, err} !== {SFetch, 3'b000}) begin bad++; $display("FAIL mid_rst_outs got=%0h want=%0h", {state_o, mem_req, IorD, err}, {SFetch, 3'b000}); end
    total++; if (instr_cnt !== 32'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d want=0", instr_cnt); end
    @(posedge clk); #1;
    rst = 1'b1; #1;
    total++; if ({state_o, mem_req, instr_cnt} !== {SFetch, 1'b1, 32'd0}) begin bad++; $display("FAIL mid_restart got=%0h want=%0h", {state_o, mem_req, instr_cnt}, {SFetch, 1'b1, 32'd0}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_lw;
    test_sw_wait;
    test_sequence;
    test_illegal;
    test_timeout;
    test_reset_mid_access;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
